// File: rtl/iob_native_arbiter_2to1.sv
// rtl/iob_native_arbiter_2to1.sv - round-robin 2:1 arbiter for one IOb-native slave port
//
// Ports:
//   clk_i, arst_n_i                      clock, asynchronous active-low reset
//   m0_* / m1_*                          IOb-native master ports (avalid/addr/wdata/wstrb in,
//                                        ready/rdata/rvalid out); wstrb==0 marks a read
//   s_*                                  IOb-native slave port
//   owner_o                              current/last granted master index
//   busy_o                               arbiter not idle
//   err_o                                sticky read-timeout flag
//
// Optional build macro IOB_NATIVE_ARBITER_TIMEOUT_EN adds a read-response watchdog of
// TIMEOUT_W bits; without it a read waits for its response indefinitely and err_o is 0.

module iob_native_arbiter_2to1 #(
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  m0_avalid_i,
  input  logic [ADDR_W-1:0]     m0_addr_i,
  input  logic [DATA_W-1:0]     m0_wdata_i,
  input  logic [DATA_W/8-1:0]   m0_wstrb_i,
  output logic                  m0_ready_o,
  output logic [DATA_W-1:0]     m0_rdata_o,
  output logic                  m0_rvalid_o,
  input  logic                  m1_avalid_i,
  input  logic [ADDR_W-1:0]     m1_addr_i,
  input  logic [DATA_W-1:0]     m1_wdata_i,
  input  logic [DATA_W/8-1:0]   m1_wstrb_i,
  output logic                  m1_ready_o,
  output logic [DATA_W-1:0]     m1_rdata_o,
  output logic                  m1_rvalid_o,
  output logic                  s_avalid_o,
  output logic [ADDR_W-1:0]     s_addr_o,
  output logic [DATA_W-1:0]     s_wdata_o,
  output logic [DATA_W/8-1:0]   s_wstrb_o,
  input  logic                  s_ready_i,
  input  logic [DATA_W-1:0]     s_rdata_i,
  input  logic                  s_rvalid_i,
  output logic                  owner_o,
  output logic                  busy_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_RD} state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;

  logic              own_avalid;
  logic              grant_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

`ifdef IOB_NATIVE_ARBITER_TIMEOUT_EN
  localparam logic [31:0]          TIMEOUT_PATTERN = 32'hDEADBEEF;
  localparam logic [TIMEOUT_W-1:0] CNT_MAX         = '1;

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;
`endif

  // Slave request is always the registered owner's request; only avalid is gated by state.
  assign own_avalid = owner_q ? m1_avalid_i : m0_avalid_i;
  assign s_addr_o   = owner_q ? m1_addr_i   : m0_addr_i;
  assign s_wdata_o  = owner_q ? m1_wdata_i  : m0_wdata_i;
  assign s_wstrb_o  = owner_q ? m1_wstrb_i  : m0_wstrb_i;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    s_avalid_o  = 1'b0;
    grant_ready = 1'b0;
    rsp_valid   = 1'b0;
    rsp_data    = '0;
`ifdef IOB_NATIVE_ARBITER_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (m0_avalid_i || m1_avalid_i) begin
          // On a tie the master that did not own the last grant wins.
          owner_d = (m0_avalid_i && m1_avalid_i) ? ~owner_q : m1_avalid_i;
          state_d = GRANT;
        end
      end
      GRANT: begin
        s_avalid_o  = own_avalid;
        grant_ready = s_ready_i;
        if (!own_avalid) begin
          state_d = IDLE;
        end else if (s_ready_i) begin
          state_d = (s_wstrb_o == '0) ? WAIT_RD : IDLE;
`ifdef IOB_NATIVE_ARBITER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT_RD: begin
        if (s_rvalid_i) begin
          rsp_valid = 1'b1;
          rsp_data  = s_rdata_i;
          state_d   = IDLE;
        end
`ifdef IOB_NATIVE_ARBITER_TIMEOUT_EN
        else if (cnt_q == CNT_MAX) begin
          rsp_valid = 1'b1;
          rsp_data  = TIMEOUT_PATTERN[DATA_W-1:0];
          err_d     = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      owner_q <= 1'b1;
`ifdef IOB_NATIVE_ARBITER_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
`ifdef IOB_NATIVE_ARBITER_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Responses reach only the owner; the other master's rdata stays 0.
  assign m0_ready_o  = grant_ready & ~owner_q;
  assign m1_ready_o  = grant_ready &  owner_q;
  assign m0_rvalid_o = rsp_valid   & ~owner_q;
  assign m1_rvalid_o = rsp_valid   &  owner_q;
  assign m0_rdata_o  = m0_rvalid_o ? rsp_data : '0;
  assign m1_rdata_o  = m1_rvalid_o ? rsp_data : '0;

  assign owner_o = owner_q;
  assign busy_o  = (state_q != IDLE);
`ifdef IOB_NATIVE_ARBITER_TIMEOUT_EN
  assign err_o   = err_q;
`else
  assign err_o   = 1'b0;
`endif

endmodule
